// File: rtl/motion_pkg.sv
// Shared definitions for the motion sequencer and its ALU.
// Latency: n/a (types, codes and a channel lookup only).
// Backpressure: n/a.
package motion_pkg;

    // ALU operand-select codes
    typedef enum logic [2:0] {
        SRC1_ACCUM  = 3'd0,
        SRC1_ITERM  = 3'd1,
        SRC1_ERROR0 = 3'd2,   // error, sign-extended
        SRC1_ERROR1 = 3'd3,   // error >>> 4, sign-extended
        SRC1_FWD    = 3'd4
    } src1_e;

    typedef enum logic [2:0] {
        SRC0_ADRES = 3'd0,
        SRC0_INTG  = 3'd1,
        SRC0_ICOM  = 3'd2,
        SRC0_PCOM  = 3'd3,
        SRC0_PTER  = 3'd4,
        SRC0_ZERO  = 3'd7     // spare code: operand forced to 0 (pass-through of src1)
    } src0_e;

    typedef enum logic [3:0] {
        IDLE, SETTLE, CONV, ACC, ERR, INTG, ICOMP, PCOMP, R1, R2, L1, L2, DONE
    } state_e;

    // A2D channel for pair index k; right sensor first, then left
    function automatic logic [2:0] chan_sel(input logic [1:0] k, input logic left);
        logic [2:0] ch;
        case (k)
            2'd0:    ch = left ? 3'd0 : 3'd1;
            2'd1:    ch = left ? 3'd2 : 3'd4;
            2'd2:    ch = left ? 3'd7 : 3'd3;
            default: ch = 3'd0;
        endcase
        return ch;
    endfunction

endpackage

// File: rtl/motion_if.sv
// Sequencer <-> ALU / A2D bundle: operand selects, ALU controls, operand registers, result.
// Latency: wires only.
// Backpressure: none; A2D completion is a single-cycle strobe.
// master: sequencer side (drives controls and operand registers, reads dst and cnv_cmplt).
// slave : ALU side (reads controls, operands and A2D_res, drives dst).
interface motion_if;
    import motion_pkg::*;

    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        cnv_cmplt;
    logic [11:0] A2D_res;
    src1_e       src1sel;
    src0_e       src0sel;
    logic        mult2, mult4, sub, saturate, multiply;
    logic [15:0] accum, pcomp;
    logic [11:0] error, intgrl, icomp, fwd, iterm;
    logic [13:0] pterm;
    logic [15:0] dst;

    modport master (
        output strt_cnv, chnnl, src1sel, src0sel, mult2, mult4, sub, saturate, multiply,
               accum, pcomp, error, intgrl, icomp, fwd, iterm, pterm,
        input  cnv_cmplt, dst
    );

    modport slave (
        input  src1sel, src0sel, mult2, mult4, sub, saturate, multiply,
               accum, pcomp, error, intgrl, icomp, fwd, iterm, pterm, A2D_res,
        output dst
    );

endinterface

// File: rtl/motion_alu.sv
// Combinational ALU: operand muxes, x2/x4 prescale, add/sub, 12-bit signed saturation, Q12 multiply.
// Latency: 0 (result valid in the same cycle as its controls).
// Backpressure: none.
// Ports: bus (motion_if.slave).
module motion_alu
    import motion_pkg::*;
(
    motion_if.slave bus
);
    logic signed [15:0] s1, s0, s0_sc;
    logic        [15:0] s0_op, sum, sat;
    logic signed [31:0] prod;
    logic               unused_prod_bits;

    always_comb begin
        s1 = 16'sd0;
        case (bus.src1sel)
            SRC1_ACCUM:  s1 = bus.accum;
            SRC1_ITERM:  s1 = {4'b0, bus.iterm};
            SRC1_ERROR0: s1 = {{4{bus.error[11]}}, bus.error};
            SRC1_ERROR1: s1 = {{8{bus.error[11]}}, bus.error[11:4]};
            SRC1_FWD:    s1 = {4'b0, bus.fwd};
            default:     s1 = 16'sd0;
        endcase

        s0 = 16'sd0;
        case (bus.src0sel)
            SRC0_ADRES: s0 = {4'b0, bus.A2D_res};
            SRC0_INTG:  s0 = {{4{bus.intgrl[11]}}, bus.intgrl};
            SRC0_ICOM:  s0 = {{4{bus.icomp[11]}}, bus.icomp};
            SRC0_PCOM:  s0 = bus.pcomp;
            SRC0_PTER:  s0 = {2'b0, bus.pterm};
            default:    s0 = 16'sd0;
        endcase

        s0_sc = bus.mult4 ? (s0 <<< 2) : (bus.mult2 ? (s0 <<< 1) : s0);
        s0_op = bus.sub ? ~s0_sc : s0_sc;
        sum   = s1 + s0_op + {15'd0, bus.sub};

        // Clamp to the 12-bit signed range, result kept sign-extended to 16 bits
        if (!sum[15] && (|sum[14:11]))
            sat = 16'h07FF;
        else if (sum[15] && !(&sum[14:11]))
            sat = 16'hF800;
        else
            sat = sum;

        prod = $signed({{16{s1[15]}}, s1}) * $signed({{16{s0[15]}}, s0});

        if (bus.multiply)
            bus.dst = prod[27:12];      // gains are Q12: drop the fraction
        else if (bus.saturate)
            bus.dst = sat;
        else
            bus.dst = sum;
    end

    // Fraction and guard bits of the product are intentionally discarded
    assign unused_prod_bits = ^{prod[31:28], prod[11:0]};

endmodule

// File: rtl/settle_tmr.sv
// 5-bit settle counter with clear/enable; tc high while count is 31 (wraps 31->0).
// Latency: tc asserted 31 enabled clocks after clear.
// Backpressure: none.
// Ports: clk, rst_n, clr, en in; tc out.
module settle_tmr (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);
    logic [4:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= 5'd0;
        else if (clr)
            cnt <= 5'd0;
        else if (en)
            cnt <= cnt + 5'd1;
    end

    assign tc = &cnt;

endmodule

// File: rtl/motion_seq.sv
// Motor-control sequencer: 3 sensor pairs -> error, integral, P/I terms, right/left commands.
// Latency: 6 x (32 settle + conversion + 1) clocks, then 9 clocks of ALU ops to done.
// Backpressure: waits indefinitely in CONV for cnv_cmplt; go is only sampled in IDLE.
// Ports: clk, rst_n, go in; done, lft, rht out; bus (motion_if.master) to ALU and A2D.
module motion_seq
    import motion_pkg::*;
#(
    parameter logic [11:0] ITERM   = 12'h500,
    parameter logic [13:0] PTERM   = 14'h3680,
    parameter logic [11:0] FWD_MAX = 12'h37F
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        go,
    motion_if.master    bus,
    output logic        done,
    output logic [11:0] lft,
    output logic [11:0] rht
);
    state_e     state, nxt;
    logic [1:0] k;          // sensor pair index
    logic       left;       // 0: right sensor of the pair, 1: left
    logic       tc;

    assign bus.iterm = ITERM;
    assign bus.pterm = PTERM;

    // Counter held clear outside SETTLE so every entry starts from 0
    settle_tmr u_tmr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state != SETTLE),
        .en    (state == SETTLE),
        .tc    (tc)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= nxt;
    end

    // Next-state logic
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (go) nxt = SETTLE;
            SETTLE:  if (tc) nxt = CONV;
            CONV:    if (bus.cnv_cmplt) nxt = ACC;
            ACC:     nxt = (left && (k == 2'd2)) ? ERR : SETTLE;
            ERR:     nxt = INTG;
            INTG:    nxt = ICOMP;
            ICOMP:   nxt = PCOMP;
            PCOMP:   nxt = R1;
            R1:      nxt = R2;
            R2:      nxt = L1;
            L1:      nxt = L2;
            L2:      nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Moore outputs
    always_comb begin
        bus.src1sel  = SRC1_ACCUM;
        bus.src0sel  = SRC0_ADRES;
        bus.mult2    = 1'b0;
        bus.mult4    = 1'b0;
        bus.sub      = 1'b0;
        bus.saturate = 1'b0;
        bus.multiply = 1'b0;
        bus.chnnl    = 3'd0;
        done         = 1'b0;
        case (state)
            SETTLE, CONV: bus.chnnl = chan_sel(k, left);
            ACC: begin
                bus.mult2 = (k == 2'd1);
                bus.mult4 = (k == 2'd2);
                bus.sub   = left;
            end
            ERR: begin
                bus.src0sel  = SRC0_ZERO;
                bus.saturate = 1'b1;
            end
            INTG: begin
                bus.src1sel  = SRC1_ERROR1;
                bus.src0sel  = SRC0_INTG;
                bus.saturate = 1'b1;
            end
            ICOMP: begin
                bus.src1sel  = SRC1_ITERM;
                bus.src0sel  = SRC0_INTG;
                bus.multiply = 1'b1;
            end
            PCOMP: begin
                bus.src1sel  = SRC1_ERROR0;
                bus.src0sel  = SRC0_PTER;
                bus.multiply = 1'b1;
            end
            R1: begin
                bus.src1sel = SRC1_FWD;
                bus.src0sel = SRC0_PCOM;
                bus.sub     = 1'b1;
            end
            R2: begin
                bus.src0sel  = SRC0_ICOM;
                bus.sub      = 1'b1;
                bus.saturate = 1'b1;
            end
            L1: begin
                bus.src1sel = SRC1_FWD;
                bus.src0sel = SRC0_PCOM;
            end
            L2: begin
                bus.src0sel  = SRC0_ICOM;
                bus.saturate = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Operand registers: each captures dst on the edge that ends its state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.accum    <= 16'd0;
            bus.pcomp    <= 16'd0;
            bus.error    <= 12'd0;
            bus.intgrl   <= 12'd0;
            bus.icomp    <= 12'd0;
            bus.fwd      <= 12'd0;
            bus.strt_cnv <= 1'b0;
            lft          <= 12'd0;
            rht          <= 12'd0;
            k            <= 2'd0;
            left         <= 1'b0;
        end else begin
            // Registered so the pulse lands in the first CONV cycle
            bus.strt_cnv <= (state == SETTLE) && tc;
            case (state)
                IDLE: if (go) begin
                    bus.accum <= 16'd0;
                    k         <= 2'd0;
                    left      <= 1'b0;
                end
                ACC: begin
                    bus.accum <= bus.dst;
                    left      <= ~left;
                    if (left) k <= k + 2'd1;
                end
                ERR:    bus.error  <= bus.dst[11:0];
                INTG:   bus.intgrl <= bus.dst[11:0];
                ICOMP:  bus.icomp  <= bus.dst[11:0];
                PCOMP:  bus.pcomp  <= bus.dst;
                R1, L1: bus.accum  <= bus.dst;
                R2:     rht        <= bus.dst[11:0];
                L2:     lft        <= bus.dst[11:0];
                DONE:   if (bus.fwd < FWD_MAX) bus.fwd <= bus.fwd + 12'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_motion_seq.sv
// Directed bench for motion_seq with the ALU at this level and a small A2D responder.
// Latency: conversion completes 2 clocks after strt_cnv.
// Backpressure: none.
module tb_motion_seq;
    import motion_pkg::*;

    // Small forward ceiling keeps the saturation scenario short
    localparam logic [11:0] FWD_LIM = 12'h005;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        go = 1'b0;
    logic        done;
    logic [11:0] lft, rht;
    logic [11:0] res_tab [8];
    bit          poke = 1'b0;
    int          n_chk = 0;
    int          n_bad = 0;

    motion_if bus ();

    motion_seq #(.FWD_MAX(FWD_LIM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .go    (go),
        .bus   (bus.master),
        .done  (done),
        .lft   (lft),
        .rht   (rht)
    );

    motion_alu u_alu (.bus(bus.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_tab(input logic [11:0] r, input logic [11:0] l);
        for (int i = 0; i < 8; i++) res_tab[i] = 12'h000;
        res_tab[1] = r; res_tab[4] = r; res_tab[3] = r;
        res_tab[0] = l; res_tab[2] = l; res_tab[7] = l;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // One control cycle: returns strt_cnv latency (edges after go raised), accum seen in ERR,
    // and the channel shown in the first SETTLE. Ends in the DONE cycle.
    task automatic do_run(output int lat, output logic [15:0] acc_err, output logic [2:0] ch1);
        bit ok;
        ok = 1'b0; lat = -1; acc_err = 16'hDEAD; ch1 = 3'd0;
        @(posedge clk); #1;
        go = 1'b1;
        for (int n = 1; n <= 3000; n++) begin
            @(posedge clk); #1;
            if (n == 1) go = 1'b0;
            poke = (n == 10);   // stray cnv_cmplt while settling
            if (n == 2) ch1 = bus.chnnl;
            if (bus.strt_cnv && lat < 0) lat = n;
            if (bus.saturate && bus.src0sel == SRC0_ZERO) acc_err = bus.accum;
            if (done) begin ok = 1'b1; break; end
        end
        go = 1'b0; poke = 1'b0;
        chk("run_done", {31'd0, ok}, 32'd1);
    endtask

    // A2D responder
    initial begin
        int cd;
        logic [2:0] ch;
        cd = 0; ch = 3'd0;
        bus.cnv_cmplt = 1'b0;
        bus.A2D_res   = 12'h000;
        forever begin
            @(negedge clk);
            bus.cnv_cmplt = poke;
            if (!rst_n) cd = 0;
            else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    bus.A2D_res   = res_tab[ch];
                    bus.cnv_cmplt = 1'b1;
                end
            end
            if (rst_n && bus.strt_cnv) begin
                ch = bus.chnnl;
                cd = 2;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int         lat;
        logic [15:0] ae;
        logic [2:0] ch1;
        bit         found;

        set_tab(12'h100, 12'h100);
        #12;
        chk("rst_accum", bus.accum, 32'h0);
        chk("rst_fwd", bus.fwd, 32'h0);
        chk("rst_chnnl", bus.chnnl, 32'h0);
        chk("rst_strt", bus.strt_cnv, 32'h0);
        chk("rst_done", done, 32'h0);
        chk("rst_src1", bus.src1sel, 32'h0);
        chk("rst_src0", bus.src0sel, 32'h0);
        chk("rst_ctl", {bus.mult2, bus.mult4, bus.sub, bus.saturate, bus.multiply}, 32'h0);
        chk("rst_lft", lft, 32'h0);
        chk("rst_rht", rht, 32'h0);
        chk("iterm", bus.iterm, 32'h500);
        chk("pterm", bus.pterm, 32'h3680);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Balanced sensors: everything nets to zero
        do_run(lat, ae, ch1);
        chk("strt_lat", lat, 32'd33);
        chk("first_chnnl", ch1, 32'd1);
        chk("bal_acc_err", ae, 32'h0);
        chk("bal_error", bus.error, 32'h0);
        chk("bal_intgrl", bus.intgrl, 32'h0);
        chk("bal_rht", rht, 32'h0);
        chk("bal_lft", lft, 32'h0);
        chk("bal_fwd_pre", bus.fwd, 32'h0);
        @(posedge clk); #1;
        chk("done_one_cycle", done, 32'h0);
        chk("bal_fwd_post", bus.fwd, 32'h1);

        // Right-heavy
        do_reset();
        set_tab(12'h100, 12'h000);
        do_run(lat, ae, ch1);
        chk("rh_acc_err", ae, 32'h0700);
        chk("rh_error", bus.error, 32'h700);
        chk("rh_intgrl", bus.intgrl, 32'h070);
        chk("rh_pcomp", bus.pcomp, 32'h17D8);
        chk("rh_icomp", bus.icomp, 32'h023);
        chk("rh_rht", rht, 32'h800);
        chk("rh_lft", lft, 32'h7FF);
        // Second cycle: integral accumulates
        do_run(lat, ae, ch1);
        chk("rh2_intgrl", bus.intgrl, 32'h0E0);
        chk("rh2_icomp", bus.icomp, 32'h046);
        chk("rh2_fwd_pre", bus.fwd, 32'h1);

        // Full-scale right: error saturates
        do_reset();
        set_tab(12'hFFF, 12'h000);
        do_run(lat, ae, ch1);
        chk("fs_acc_err", ae, 32'h6FF9);
        chk("fs_error", bus.error, 32'h7FF);
        chk("fs_intgrl", bus.intgrl, 32'h07F);

        // Left-heavy: negative error path
        do_reset();
        set_tab(12'h000, 12'h100);
        do_run(lat, ae, ch1);
        chk("lh_acc_err", ae, 32'hF900);
        chk("lh_error", bus.error, 32'h900);
        chk("lh_intgrl", bus.intgrl, 32'hF90);
        chk("lh_pcomp", bus.pcomp, 32'hE828);
        chk("lh_icomp", bus.icomp, 32'hFDD);
        chk("lh_rht", rht, 32'h7FF);
        chk("lh_lft", lft, 32'h800);

        // Reset while converting the right sensor of pair 1
        @(posedge clk); #1;
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 500; n++) begin
            @(posedge clk); #1;
            if (bus.chnnl == 3'd4 && bus.strt_cnv) begin found = 1'b1; break; end
        end
        chk("reach_conv_k1", {31'd0, found}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_accum", bus.accum, 32'h0);
        chk("mid_rst_fwd", bus.fwd, 32'h0);
        chk("mid_rst_lft", lft, 32'h0);
        chk("mid_rst_rht", rht, 32'h0);
        chk("mid_rst_error", bus.error, 32'h0);
        chk("mid_rst_intgrl", bus.intgrl, 32'h0);
        chk("mid_rst_pcomp", bus.pcomp, 32'h0);
        chk("mid_rst_icomp", bus.icomp, 32'h0);
        chk("mid_rst_chnnl", bus.chnnl, 32'h0);
        chk("mid_rst_strt", bus.strt_cnv, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        chk("restart_chnnl", bus.chnnl, 32'd1);

        // Forward speed ramps then holds at the ceiling; zero error makes rht/lft track fwd
        do_reset();
        set_tab(12'h100, 12'h100);
        for (int i = 0; i < int'(FWD_LIM) + 2; i++) begin
            do_run(lat, ae, ch1);
            chk("ramp_fwd", bus.fwd, (i < int'(FWD_LIM)) ? i : int'(FWD_LIM));
            chk("ramp_rht", rht, (i < int'(FWD_LIM)) ? i : int'(FWD_LIM));
        end
        @(posedge clk); #1;
        chk("fwd_ceiling", bus.fwd, {20'd0, FWD_LIM});

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
